// File: rtl/bcd2_7seg_mux.sv
// Two-digit multiplexed 7-segment driver: latches a units/tens BCD pair and time-multiplexes it.
// Latency: outputs registered, one cycle behind the slot counter and held digits.
// No backpressure: load is accepted unconditionally on any edge; blank only gates the display.
module bcd2_7seg_mux #(
    parameter int REFRESH_DIV    = 50000,
    parameter int GUARD          = 4,
    parameter int BLANK_LZ       = 1,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DIG_ACTIVE_LOW = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] uni,
    input  logic [3:0] dec,
    input  logic       blank,
    output logic [6:0] seg,
    output logic [1:0] dig_en,
    output logic       frame,
    output logic       err
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] CNT_GUARD = CW'(GUARD);
    // XOR masks turn active-high internal codes into pin polarity
    localparam logic [6:0] SEG_XOR = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [1:0] DIG_XOR = (DIG_ACTIVE_LOW != 0) ? 2'b11 : 2'b00;

    logic [3:0]    uni_q;
    logic [3:0]    dec_q;
    logic [CW-1:0] cnt;
    logic          slot;        // 0 = units slot, 1 = tens slot
    logic          slot_end;
    logic [6:0]    seg_nxt;     // active-high segment code
    logic [1:0]    dig_nxt;     // active-high digit enables

    // BCD to gfedcba, anything above 9 shows a dash
    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'd0:    decode = 7'h3F;
            4'd1:    decode = 7'h06;
            4'd2:    decode = 7'h5B;
            4'd3:    decode = 7'h4F;
            4'd4:    decode = 7'h66;
            4'd5:    decode = 7'h6D;
            4'd6:    decode = 7'h7D;
            4'd7:    decode = 7'h07;
            4'd8:    decode = 7'h7F;
            4'd9:    decode = 7'h6F;
            default: decode = 7'h40;
        endcase
    endfunction

    assign slot_end = (cnt == CNT_LAST);

    // Held digits, slot counter and active-slot toggle
    always_ff @(posedge clk) begin
        if (rst) begin
            uni_q <= 4'd0;
            dec_q <= 4'd0;
            cnt   <= '0;
            slot  <= 1'b0;
        end else begin
            if (load) begin
                uni_q <= uni;
                dec_q <= dec;
            end
            if (slot_end) begin
                cnt  <= '0;
                slot <= ~slot;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Select what the next display cycle shows; guard gap keeps both digits dark to stop ghosting
    always_comb begin
        seg_nxt = 7'h00;
        dig_nxt = 2'b00;
        if (!blank && (cnt >= CNT_GUARD)) begin
            if (!slot) begin
                seg_nxt = decode(uni_q);
                dig_nxt = 2'b01;
            end else if (!((BLANK_LZ != 0) && (dec_q == 4'd0))) begin
                // an invalid tens code is nonzero, so it is never suppressed here
                seg_nxt = decode(dec_q);
                dig_nxt = 2'b10;
            end
        end
    end

    // Registered pin outputs with polarity applied, frame pulse and error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            seg    <= SEG_XOR;
            dig_en <= DIG_XOR;
            frame  <= 1'b0;
            err    <= 1'b0;
        end else begin
            seg    <= seg_nxt ^ SEG_XOR;
            dig_en <= dig_nxt ^ DIG_XOR;
            frame  <= slot_end & slot;
            err    <= (uni_q > 4'd9) | (dec_q > 4'd9);
        end
    end

endmodule

// File: tb/tb_bcd2_7seg_mux.sv
// Bench for bcd2_7seg_mux: three instances (blanking on, blanking off, active-low pins).
// Expected values come from a time-since-reset model pushed to a scoreboard queue per edge.
// Table of digit pairs plus hand-written reset, frame, blank and mid-slot reset sequences.
module tb_bcd2_7seg_mux;

    localparam int RD = 8;
    localparam int GD = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic [3:0] uni;
    logic [3:0] dec;
    logic       blank;

    logic [6:0] seg, seg_nb, seg_al;
    logic [1:0] dig, dig_nb, dig_al;
    logic       frame, frame_nb, frame_al;
    logic       err, err_nb, err_al;

    always #5 clk = ~clk;

    bcd2_7seg_mux #(.REFRESH_DIV(RD), .GUARD(GD), .BLANK_LZ(1), .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)) dut (
        .clk(clk), .rst(rst), .load(load), .uni(uni), .dec(dec), .blank(blank),
        .seg(seg), .dig_en(dig), .frame(frame), .err(err));

    bcd2_7seg_mux #(.REFRESH_DIV(RD), .GUARD(GD), .BLANK_LZ(0), .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)) dut_nb (
        .clk(clk), .rst(rst), .load(load), .uni(uni), .dec(dec), .blank(blank),
        .seg(seg_nb), .dig_en(dig_nb), .frame(frame_nb), .err(err_nb));

    bcd2_7seg_mux #(.REFRESH_DIV(RD), .GUARD(GD)) dut_al (
        .clk(clk), .rst(rst), .load(load), .uni(uni), .dec(dec), .blank(blank),
        .seg(seg_al), .dig_en(dig_al), .frame(frame_al), .err(err_al));

    typedef struct {
        logic [6:0] seg, seg_nb, seg_al;
        logic [1:0] dig, dig_nb, dig_al;
        logic       frame, err;
    } exp_t;

    typedef struct {
        logic [3:0] u, d;
        logic [6:0] useg, tseg;
        logic [1:0] tdig;
        logic       e;
    } vec_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    // model state: edges since reset release and held digits
    int         m_t = 0;
    logic [3:0] h_uni = 4'd0;
    logic [3:0] h_dec = 4'd0;
    int         last_c = 0;
    int         last_s = 0;
    logic       last_blank = 1'b0;

    function automatic logic [6:0] code7(input logic [3:0] v);
        logic [6:0] t [16];
        t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F,
              7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
        return t[v];
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // one clock edge: predict, enqueue, clock, dequeue and compare all instances
    task automatic step();
        exp_t e;
        int   c, s;
        c = m_t % RD;
        s = (m_t / RD) % 2;
        e.seg = 7'h00; e.seg_nb = 7'h00; e.seg_al = 7'h7F;
        e.dig = 2'b00; e.dig_nb = 2'b00; e.dig_al = 2'b11;
        e.frame = 1'b0; e.err = 1'b0;
        if (!rst) begin
            e.err   = (h_uni > 9) || (h_dec > 9);
            e.frame = (m_t % (2 * RD)) == (2 * RD - 1);
            if (!blank && c >= GD) begin
                if (s == 0) begin
                    e.seg = code7(h_uni); e.dig = 2'b01;
                    e.seg_nb = e.seg;     e.dig_nb = 2'b01;
                    e.seg_al = ~e.seg;    e.dig_al = 2'b10;
                end else begin
                    e.seg_nb = code7(h_dec); e.dig_nb = 2'b10;
                    if (h_dec != 4'd0) begin
                        e.seg = e.seg_nb;     e.dig = 2'b10;
                        e.seg_al = ~e.seg_nb; e.dig_al = 2'b01;
                    end
                end
            end
        end
        last_c = c;
        last_s = s;
        last_blank = blank;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (rst) begin
            m_t = 0; h_uni = 4'd0; h_dec = 4'd0;
        end else begin
            if (load) begin
                h_uni = uni; h_dec = dec;
            end
            m_t++;
        end
        e = exp_q.pop_front();
        chk("seg",      {1'b0, seg},      {1'b0, e.seg});
        chk("dig_en",   {6'd0, dig},      {6'd0, e.dig});
        chk("seg_nb",   {1'b0, seg_nb},   {1'b0, e.seg_nb});
        chk("dig_nb",   {6'd0, dig_nb},   {6'd0, e.dig_nb});
        chk("seg_al",   {1'b0, seg_al},   {1'b0, e.seg_al});
        chk("dig_al",   {6'd0, dig_al},   {6'd0, e.dig_al});
        chk("frame",    {7'd0, frame},    {7'd0, e.frame});
        chk("frame_al", {7'd0, frame_al}, {7'd0, e.frame});
        chk("err",      {7'd0, err},      {7'd0, e.err});
        chk("err_nb",   {7'd0, err_nb},   {7'd0, e.err});
    endtask

    task automatic load_pair(input logic [3:0] u, input logic [3:0] d);
        uni = u; dec = d; load = 1'b1;
        step();
        load = 1'b0;
    endtask

    vec_t vecs [6];
    int   n;
    int   nframes;

    initial begin
        vecs[0] = '{u: 4'd7,  d: 4'd4,  useg: 7'h07, tseg: 7'h66, tdig: 2'b10, e: 1'b0};
        vecs[1] = '{u: 4'd5,  d: 4'd0,  useg: 7'h6D, tseg: 7'h00, tdig: 2'b00, e: 1'b0};
        vecs[2] = '{u: 4'd12, d: 4'd3,  useg: 7'h40, tseg: 7'h4F, tdig: 2'b10, e: 1'b1};
        vecs[3] = '{u: 4'd1,  d: 4'd3,  useg: 7'h06, tseg: 7'h4F, tdig: 2'b10, e: 1'b0};
        vecs[4] = '{u: 4'd0,  d: 4'd15, useg: 7'h3F, tseg: 7'h40, tdig: 2'b10, e: 1'b1};
        vecs[5] = '{u: 4'd9,  d: 4'd9,  useg: 7'h6F, tseg: 7'h6F, tdig: 2'b10, e: 1'b0};

        rst = 1'b1; load = 1'b0; uni = 4'd0; dec = 4'd0; blank = 1'b0;
        repeat (3) step();
        chk("reset_seg", {1'b0, seg}, 8'h00);
        chk("reset_dig", {6'd0, dig}, 8'h00);

        // first units enable lands on the third edge after reset release
        rst = 1'b0;
        n = 0;
        do begin
            step();
            n++;
        end while (dig !== 2'b01 && n < 10);
        chk("first_units_edge", 8'(n), 8'd3);

        // table: load each pair, then check one full refresh against table values
        for (int i = 0; i < 6; i++) begin
            load_pair(vecs[i].u, vecs[i].d);
            repeat (2 * RD) begin
                step();
                if (!last_blank && last_c >= GD) begin
                    if (last_s == 0) begin
                        chk("tbl_useg", {1'b0, seg}, {1'b0, vecs[i].useg});
                        chk("tbl_udig", {6'd0, dig}, 8'h01);
                    end else begin
                        chk("tbl_tseg", {1'b0, seg}, {1'b0, vecs[i].tseg});
                        chk("tbl_tdig", {6'd0, dig}, {6'd0, vecs[i].tdig});
                        if (vecs[i].d == 4'd0)
                            chk("tbl_tseg_nolz", {1'b0, seg_nb}, 8'h3F);
                    end
                end
                chk("tbl_err", {7'd0, err}, {7'd0, vecs[i].e});
            end
        end

        // frame pulses exactly twice in 32 cycles
        load_pair(4'd7, 4'd4);
        nframes = 0;
        repeat (4 * RD) begin
            step();
            if (frame === 1'b1) nframes++;
        end
        chk("frame_count", 8'(nframes), 8'd2);

        // blank mid-units slot, then release and keep running
        n = 0;
        while (!(((m_t % RD) == 4) && (((m_t / RD) % 2) == 0)) && n < 40) begin
            step();
            n++;
        end
        chk("reach_units_mid", {7'd0, n < 40}, 8'd1);
        blank = 1'b1;
        step();
        chk("blank_seg", {1'b0, seg}, 8'h00);
        chk("blank_dig", {6'd0, dig}, 8'h00);
        repeat (5) step();
        blank = 1'b0;
        repeat (2 * RD + 4) step();

        // active-low instance, reset asserted mid-tens slot
        load_pair(4'd8, 4'd8);
        n = 0;
        while (!(((m_t % RD) == 4) && (((m_t / RD) % 2) == 1)) && n < 40) begin
            step();
            n++;
        end
        chk("reach_tens_mid", {7'd0, n < 40}, 8'd1);
        step();
        chk("al_tens_seg", {1'b0, seg_al}, 8'h00);
        chk("al_tens_dig", {6'd0, dig_al}, 8'h01);
        rst = 1'b1;
        step();
        chk("al_rst_seg", {1'b0, seg_al}, 8'h7F);
        chk("al_rst_dig", {6'd0, dig_al}, 8'h03);
        rst = 1'b0;
        repeat (3) step();
        chk("al_restart_units", {6'd0, dig_al}, 8'h02);
        load_pair(4'd8, 4'd8);
        repeat (RD) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
